pes_bm_sched: RTL and testbench

PES_BM_SCHED -- requirements
Module: pes_bm_sched

---
 rtl/pes_bm_if.sv | 36 +++
 rtl/pes_bm_sched.sv | 127 ++++++++++++
 tb/tb_pes_bm_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pes_bm_if.sv
// Bus bundle between the two requesters, the result consumer and the shared
// Booth multiplier on one side, and the pes_bm_sched scheduler on the other.
interface pes_bm_if;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [3:0] req0_m;
    logic [3:0] req0_q;
    logic [3:0] req1_m;
    logic [3:0] req1_q;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_p;
    logic       mul_load;
    logic [3:0] mul_M;
    logic [3:0] mul_Q;
    logic [7:0] mul_P;

    // Scheduler side
    modport slave (
        input  req0_valid, req1_valid, req0_m, req0_q, req1_m, req1_q,
        input  rsp_ready, mul_P,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p,
        output mul_load, mul_M, mul_Q
    );

    // Environment side (requesters, consumer, multiplier)
    modport master (
        output req0_valid, req1_valid, req0_m, req0_q, req1_m, req1_q,
        output rsp_ready, mul_P,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p,
        input  mul_load, mul_M, mul_Q
    );
endinterface

// File: rtl/pes_bm_sched.sv
// pes_bm_sched: round-robin scheduler sharing one 4-bit Booth multiplier
// between two requesters. Optional macro PES_BM_ZERO_BYPASS_EN short-cuts
// operations with a zero operand straight to DONE with a zero product.
module pes_bm_sched #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic     clk,
    input  logic     reset,
    pes_bm_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic [3:0]         m_q, m_d;
    logic [3:0]         q_q, q_d;
    logic [7:0]         rsp_p_q, rsp_p_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               mul_load_q, mul_load_d;

    logic               gnt_c;
    logic               hs_c;
    logic [3:0]         sel_m_c;
    logic [3:0]         sel_q_c;

    // Grant: alternate on contention, follow the lone requester, else keep preference
    assign gnt_c = (bus.req0_valid && bus.req1_valid) ? ~last_q :
                   bus.req1_valid                     ? 1'b1    :
                   bus.req0_valid                     ? 1'b0    : ~last_q;

    assign hs_c    = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign sel_m_c = gnt_c ? bus.req1_m : bus.req0_m;
    assign sel_q_c = gnt_c ? bus.req1_q : bus.req0_q;

    assign bus.req0_ready = (state_q == IDLE) && !gnt_c;
    assign bus.req1_ready = (state_q == IDLE) &&  gnt_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_p      = rsp_p_q;
    assign bus.mul_load   = mul_load_q;
    assign bus.mul_M      = m_q;
    assign bus.mul_Q      = q_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            m_q         <= '0;
            q_q         <= '0;
            rsp_p_q     <= '0;
            rsp_valid_q <= 1'b0;
            mul_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            id_q        <= id_d;
            m_q         <= m_d;
            q_q         <= q_d;
            rsp_p_q     <= rsp_p_d;
            rsp_valid_q <= rsp_valid_d;
            mul_load_q  <= mul_load_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        id_d        = id_q;
        m_d         = m_q;
        q_d         = q_q;
        rsp_p_d     = rsp_p_q;
        rsp_valid_d = rsp_valid_q;
        mul_load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    id_d = gnt_c;
                    m_d  = sel_m_c;
                    q_d  = sel_q_c;
`ifdef PES_BM_ZERO_BYPASS_EN
                    if ((sel_m_c == 4'd0) || (sel_q_c == 4'd0)) begin
                        state_d     = DONE;
                        rsp_p_d     = '0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d    = LOAD;
                        mul_load_d = 1'b1;
                    end
`else
                    state_d    = LOAD;
                    mul_load_d = 1'b1;
`endif
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = CNT_W'(MUL_LAT);
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    rsp_p_d     = bus.mul_P;
                    rsp_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    last_d      = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pes_bm_sched.sv
// Self-checking bench for pes_bm_sched: requester drivers, a multiplier model
// with MUL_LAT latency, and a scoreboard of expected responses.
module tb_pes_bm_sched;
    localparam int unsigned MUL_LAT  = 4;
    localparam int          NORM_LAT = MUL_LAT + 2;
    localparam int          ISSUE    = MUL_LAT + 3;
`ifdef PES_BM_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic       id;
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] p;
    } op_t;

    typedef struct {
        logic       id;
        logic [7:0] p;
        int         hs_cyc;
        int         lat;
        int         loads;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pes_bm_if bus();
    pes_bm_sched #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    op_t  pend0[$];
    op_t  pend1[$];
    exp_t sb[$];
    int   hs_id[$];
    int   hs_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    op_t  tbl[8];

    bit                 prev_v, prev_r, mul_load_s, reset_s;
    logic [7:0]         prev_p;
    logic               prev_id;
    int                 load_cnt, lat_cnt;
    logic signed [7:0]  am, bq, prod;
    logic [3:0]         sm, sq;
    op_t                op;
    exp_t               e;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk_exp(input op_t o, input int c);
        exp_t x;
        bit   z;
        z        = (o.m == 4'd0) || (o.q == 4'd0);
        x.id     = o.id;
        x.p      = o.p;
        x.hs_cyc = c;
        x.lat    = (BYPASS && z) ? 1 : NORM_LAT;
        x.loads  = (BYPASS && z) ? 0 : 1;
        return x;
    endfunction

    // Requester drivers, scoreboard and multiplier model
    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_m = '0; bus.req0_q = '0; bus.req1_m = '0; bus.req1_q = '0;
        bus.mul_P = '0;
        prev_v = 1'b0; prev_r = 1'b0; prev_p = '0; prev_id = 1'b0;
        load_cnt = 0; lat_cnt = 0; prod = '0;
        forever begin
            @(negedge clk);
            cyc++;
            reset_s = reset;
            if (!reset) begin
                prev_v   = 1'b0;
                load_cnt = 0;
            end else begin
                if (bus.mul_load) load_cnt++;
                check("ready_onehot", int'(bus.req0_ready && bus.req1_ready), 0);
                if (bus.rsp_valid)
                    check("ready_in_done", int'(bus.req0_ready || bus.req1_ready), 0);
                if (prev_v && !prev_r) begin
                    check("hold_valid", int'(bus.rsp_valid), 1);
                    check("hold_p", int'(bus.rsp_p), int'(prev_p));
                    check("hold_id", int'(bus.rsp_id), int'(prev_id));
                end
                if (bus.rsp_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 p=%0h required no response", bus.rsp_p);
                    end else begin
                        check("latency", cyc - sb[0].hs_cyc, sb[0].lat);
                    end
                end
                if (bus.rsp_valid && bus.rsp_ready && (sb.size() > 0)) begin
                    e = sb.pop_front();
                    check("rsp_id", int'(bus.rsp_id), int'(e.id));
                    check("rsp_p", int'(bus.rsp_p), int'(e.p));
                    check("mul_load_cycles", load_cnt, e.loads);
                end
                if (bus.req0_valid && bus.req0_ready && (pend0.size() > 0)) begin
                    op = pend0.pop_front();
                    sb.push_back(mk_exp(op, cyc));
                    hs_id.push_back(0);
                    hs_cyc.push_back(cyc);
                    load_cnt = 0;
                end
                if (bus.req1_valid && bus.req1_ready && (pend1.size() > 0)) begin
                    op = pend1.pop_front();
                    sb.push_back(mk_exp(op, cyc));
                    hs_id.push_back(1);
                    hs_cyc.push_back(cyc);
                    load_cnt = 0;
                end
                prev_v  = bus.rsp_valid;
                prev_r  = bus.rsp_ready;
                prev_p  = bus.rsp_p;
                prev_id = bus.rsp_id;
            end
            mul_load_s = bus.mul_load;
            sm = bus.mul_M;
            sq = bus.mul_Q;

            @(posedge clk);
            #1;
            bus.req0_valid = (pend0.size() > 0);
            if (pend0.size() > 0) begin bus.req0_m = pend0[0].m; bus.req0_q = pend0[0].q; end
            bus.req1_valid = (pend1.size() > 0);
            if (pend1.size() > 0) begin bus.req1_m = pend1[0].m; bus.req1_q = pend1[0].q; end
            if (!reset_s) begin
                lat_cnt = 0;
            end else if (mul_load_s) begin
                lat_cnt   = MUL_LAT;
                bus.mul_P = 8'h5A;
                am        = {{4{sm[3]}}, sm};
                bq        = {{4{sq[3]}}, sq};
                prod      = am * bq;
            end else if (lat_cnt != 0) begin
                lat_cnt--;
                if (lat_cnt == 1) bus.mul_P = prod;
            end
        end
    end

    task automatic push_op(input op_t o);
        if (o.id) pend1.push_back(o);
        else      pend0.push_back(o);
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((pend0.size() == 0) && (pend1.size() == 0) && (sb.size() == 0) && !bus.rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got pending=%0d required 0", name, sb.size() + pend0.size() + pend1.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        pend0.delete();
        pend1.delete();
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 4'b1010, 4'b1011, 8'h1E};
        tbl[1] = '{1'b1, 4'b0100, 4'b0100, 8'h10};
        tbl[2] = '{1'b0, 4'b0000, 4'b0101, 8'h00};
        tbl[3] = '{1'b1, 4'b1000, 4'b1000, 8'h40};
        tbl[4] = '{1'b0, 4'b0111, 4'b0111, 8'h31};
        tbl[5] = '{1'b1, 4'b1000, 4'b0111, 8'hC8};
        tbl[6] = '{1'b1, 4'b0101, 4'b0000, 8'h00};
        tbl[7] = '{1'b0, 4'b1111, 4'b1111, 8'h01};

        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_rsp_p", int'(bus.rsp_p), 0);
        check("rst_rsp_id", int'(bus.rsp_id), 0);
        check("rst_mul_load", int'(bus.mul_load), 0);
        check("rst_mul_M", int'(bus.mul_M), 0);
        check("rst_mul_Q", int'(bus.mul_Q), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_req0_ready", int'(bus.req0_ready), 1);
        check("post_rst_req1_ready", int'(bus.req1_ready), 0);

        // Single-requester operations from the vector table
        for (int i = 0; i < 8; i++) begin
            push_op(tbl[i]);
            wait_drain("single", 60);
        end

        // Simultaneous requests after reset: requester 0 first
        do_reset();
        hs_id.delete(); hs_cyc.delete();
        push_op('{1'b0, 4'b0011, 4'b0010, 8'h06});
        push_op('{1'b1, 4'b0111, 4'b1111, 8'hF9});
        wait_drain("both", 100);
        if (hs_id.size() == 2) begin
            check("both_first", hs_id[0], 0);
            check("both_second", hs_id[1], 1);
            check("both_interval", hs_cyc[1] - hs_cyc[0], ISSUE);
        end else check("both_count", hs_id.size(), 2);

        // Consumer back-pressure for 5 cycles in DONE with the other requester waiting
        hs_id.delete(); hs_cyc.delete();
        bus.rsp_ready = 1'b0;
        push_op('{1'b0, 4'b0011, 4'b0011, 8'h09});
        push_op('{1'b1, 4'b0010, 4'b0011, 8'h06});
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        check("hold_reached_done", int'(bus.rsp_valid), 1);
        repeat (5) @(negedge clk);
        check("hold_no_new_grant", hs_id.size(), 1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_drain("hold", 100);
        check("hold_total_grants", hs_id.size(), 2);

        // Reset in the middle of RUN discards the operation
        push_op('{1'b0, 4'b0110, 4'b0110, 8'h24});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mul_load) break;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rsp_valid", int'(bus.rsp_valid), 0);
        check("midrun_req0_ready", int'(bus.req0_ready), 1);
        push_op('{1'b0, 4'b0100, 4'b0100, 8'h10});
        wait_drain("midrun", 60);

        // Both requesters continuously valid: alternating grants at the issue interval
        do_reset();
        hs_id.delete(); hs_cyc.delete();
        push_op('{1'b0, 4'b0010, 4'b0011, 8'h06});
        push_op('{1'b0, 4'b1110, 4'b0011, 8'hFA});
        push_op('{1'b1, 4'b0101, 4'b0011, 8'h0F});
        push_op('{1'b1, 4'b1101, 4'b0011, 8'hF7});
        wait_drain("alt", 200);
        if (hs_id.size() == 4) begin
            for (int i = 0; i < 4; i++) check("alt_grant", hs_id[i], i % 2);
            for (int i = 1; i < 4; i++) check("alt_interval", hs_cyc[i] - hs_cyc[i-1], ISSUE);
        end else check("alt_count", hs_id.size(), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
